// File: rtl/stage_if_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage and its cache.
package stage_if_pkg;

    localparam int ADDR_W  = 32;
    localparam int INST_W  = 32;
    localparam int BYTE_W  = 8;
    localparam int STALL_W = 6;

    // Stall vector bit positions
    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0;

    typedef logic [ADDR_W-1:0] mem_addr_t;
    typedef logic [INST_W-1:0] inst_t;
    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        IF_CHECK = 2'd0,
        IF_FETCH = 2'd1,
        IF_READY = 2'd2
    } if_state_e;

    function automatic mem_addr_t align_word(input mem_addr_t a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/stage_if_icache.sv
// Direct-mapped instruction cache: combinational lookup, synchronous fill.
// Zero-latency hit; write takes effect next cycle; valid bits cleared on reset.
module icache_dm
    import stage_if_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [29:0]   rd_word,
    output logic          hit,
    output inst_t         rd_data,
    input  logic          we,
    input  logic [29:0]   wr_word,
    input  inst_t         wr_data
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    logic              valid_q [ENTRIES];
    logic              valid_d [ENTRIES];
    logic [TAG_W-1:0]  tag_q   [ENTRIES];
    logic [TAG_W-1:0]  tag_d   [ENTRIES];
    inst_t             data_q  [ENTRIES];
    inst_t             data_d  [ENTRIES];

    logic [IDX_W-1:0]  rd_idx;
    logic [TAG_W-1:0]  rd_tag;
    logic [IDX_W-1:0]  wr_idx;
    logic [TAG_W-1:0]  wr_tag;

    assign rd_idx = rd_word[IDX_W-1:0];
    assign rd_tag = rd_word[29:IDX_W];
    assign wr_idx = wr_word[IDX_W-1:0];
    assign wr_tag = wr_word[29:IDX_W];

    always_comb begin
        hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_data = data_q[rd_idx];
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (we) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
            data_d[wr_idx]  = wr_data;
        end
    end

    // Tag and data need no reset: a clear valid bit masks them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            valid_q <= valid_d;
        end
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/stage_if.sv
// Instruction fetch: cache hit presents in the same cycle; a miss assembles 4 bytes, READY 6 cycles later.
// stall[1] holds a presented instruction; decode redirect squashes and restarts; fills ignore stalls.
module stage_if
    import stage_if_pkg::*;
#(
    parameter int        ICACHE_IDX_W = 4,
    parameter mem_addr_t RESET_PC     = 32'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STALL_W-1:0] stall,
    output logic               stall_if,
    input  logic               br,
    input  mem_addr_t          br_addr,
    output mem_addr_t          pc,
    output inst_t              inst,
    output logic               mem_req,
    output mem_addr_t          mem_addr,
    input  logic               mem_grant,
    input  byte_t              mem_rdata
);

    if_state_e  state_q, state_d;
    mem_addr_t  pc_reg_q, pc_reg_d;
    logic [2:0] ic_q, ic_d;
    logic [2:0] rc_q, rc_d;
    inst_t      word_q, word_d;
    logic       pend_q, pend_d;
    logic       drop_q, drop_d;

    logic       redirect;
    logic       accept;
    logic       req;
    logic       byte_vld;
    logic       fetch_done;
    logic       cache_hit;
    inst_t      cache_data;
    logic       cache_we;
    logic       stall_unused;

    assign stall_unused = ^{stall[STALL_W-1:3], stall[0], br_addr[1:0]};

    assign redirect   = br && !stall[STALL_ID];
    assign accept     = !stall[STALL_IF];
    assign req        = (state_q == IF_FETCH) && !ic_q[2];
    // A byte is only ours if it was granted last cycle and not orphaned by a redirect.
    assign byte_vld   = (state_q == IF_FETCH) && pend_q && !drop_q;
    assign fetch_done = byte_vld && (rc_q == 3'd3);
    assign cache_we   = fetch_done && !redirect;

    icache_dm #(
        .IDX_W (ICACHE_IDX_W)
    ) u_icache (
        .clk     (clk),
        .reset   (reset),
        .rd_word (pc_reg_q[31:2]),
        .hit     (cache_hit),
        .rd_data (cache_data),
        .we      (cache_we),
        .wr_word (pc_reg_q[31:2]),
        .wr_data (word_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IF_CHECK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = IF_CHECK;
        end else begin
            case (state_q)
                IF_CHECK: if (!cache_hit) state_d = IF_FETCH;
                IF_FETCH: if (fetch_done) state_d = IF_READY;
                IF_READY: if (accept)     state_d = IF_CHECK;
                default:                  state_d = IF_CHECK;
            endcase
        end
    end

    always_comb begin
        pc_reg_d = pc_reg_q;
        ic_d     = ic_q;
        rc_d     = rc_q;
        word_d   = word_q;
        pend_d   = req && mem_grant && !redirect;
        drop_d   = req && mem_grant && redirect;
        if (redirect) begin
            pc_reg_d = align_word(br_addr);
            ic_d     = 3'd0;
            rc_d     = 3'd0;
            word_d   = NOP_INST;
        end else begin
            case (state_q)
                IF_CHECK: begin
                    ic_d   = 3'd0;
                    rc_d   = 3'd0;
                    word_d = NOP_INST;
                    if (cache_hit && accept) pc_reg_d = pc_reg_q + 32'd4;
                end
                IF_FETCH: begin
                    if (req && mem_grant) ic_d = ic_q + 3'd1;
                    if (byte_vld) begin
                        word_d[{rc_q[1:0], 3'b000} +: BYTE_W] = mem_rdata;
                        rc_d = rc_q + 3'd1;
                    end
                end
                IF_READY: begin
                    if (accept) begin
                        pc_reg_d = pc_reg_q + 32'd4;
                        ic_d     = 3'd0;
                        rc_d     = 3'd0;
                    end
                end
                default: begin
                    ic_d = 3'd0;
                    rc_d = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg_q <= RESET_PC;
            ic_q     <= 3'd0;
            rc_q     <= 3'd0;
            word_q   <= NOP_INST;
            pend_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            pc_reg_q <= pc_reg_d;
            ic_q     <= ic_d;
            rc_q     <= rc_d;
            word_q   <= word_d;
            pend_q   <= pend_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        pc       = '0;
        inst     = NOP_INST;
        stall_if = 1'b0;
        mem_req  = 1'b0;
        mem_addr = '0;
        if (!reset) begin
            pc       = pc_reg_q;
            mem_req  = req;
            mem_addr = pc_reg_q + {29'b0, ic_q};
            case (state_q)
                IF_CHECK: begin
                    stall_if = !cache_hit;
                    inst     = cache_hit ? cache_data : NOP_INST;
                end
                IF_FETCH: stall_if = 1'b1;
                IF_READY: inst = word_q;
                default:  stall_if = 1'b1;
            endcase
            // Decode is taking a branch: hand it a bubble this cycle.
            if (redirect) inst = NOP_INST;
        end
    end

endmodule

// File: tb/tb_stage_if.sv
module tb_stage_if;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  stall;
    logic        stall_if;
    logic        br;
    logic [31:0] br_addr;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_grant;
    logic [7:0]  mem_rdata;

    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  mem_model [1024];
    int          compared   = 0;
    int          mismatched = 0;
    int          accepts    = 0;

    stage_if #(
        .ICACHE_IDX_W (4),
        .RESET_PC     (RESET_PC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .stall_if  (stall_if),
        .br        (br),
        .br_addr   (br_addr),
        .pc        (pc),
        .inst      (inst),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_grant (mem_grant),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [9:0] b;
        b = {a[9:2], 2'b00};
        return {mem_model[b + 10'd3], mem_model[b + 10'd2], mem_model[b + 10'd1], mem_model[b]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_restart(input logic [31:0] a);
        exp_t e;
        e.pc   = {a[31:2], 2'b00};
        e.inst = word_at(e.pc);
        sb_q.delete();
        sb_q.push_back(e);
    endtask

    // Program-order model: reset or a taken redirect restarts the expected stream.
    task automatic track();
        if (reset) sb_restart(RESET_PC);
        else if (br && !stall[2]) sb_restart(br_addr);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: a byte granted in one cycle is driven during the next; junk otherwise.
    initial begin
        logic        g;
        logic [31:0] a;
        mem_rdata = 8'hEE;
        forever begin
            @(negedge clk);
            g = mem_req && mem_grant && !reset;
            a = mem_addr;
            @(posedge clk);
            #1;
            mem_rdata = g ? mem_model[a[9:0]] : 8'hEE;
        end
    end

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_pc", pc, 32'h0);
                chk("rst_inst", inst, 32'h0);
                chk("rst_addr", mem_addr, 32'h0);
                chk("rst_ctl", 32'({stall_if, mem_req}), 32'h0);
            end else if (stall_if) begin
                chk("stall_inst_bubble", inst, 32'h0);
            end else if (br && !stall[2]) begin
                chk("squash_inst", inst, 32'h0);
            end else begin
                chk("present_no_req", 32'(mem_req), 32'h0);
                if (sb_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL sb_empty: got pc %h with no expected entry", pc);
                end else begin
                    e = sb_q[0];
                    chk("sb_pc", pc, e.pc);
                    chk("sb_inst", inst, e.inst);
                    if (!stall[1]) begin
                        void'(sb_q.pop_front());
                        accepts++;
                        e.pc   = e.pc + 32'd4;
                        e.inst = word_at(e.pc);
                        sb_q.push_back(e);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] ea;
        logic        do_addr;
        for (int i = 0; i < 1024; i++) mem_model[i] = 8'($urandom);
        mem_model[0] = 8'h93;
        mem_model[1] = 8'h00;
        mem_model[2] = 8'h10;
        mem_model[3] = 8'h00;

        reset = 1'b1; stall = '0; br = 1'b0; br_addr = '0; mem_grant = 1'b1;
        track();
        next_cycle();
        next_cycle();

        // Directed timeline; t=0 is the first cycle out of reset.
        for (int t = 0; t <= 53; t++) begin
            reset     = (t == 46);
            stall     = (t >= 6 && t <= 9) ? 6'b000010 : 6'b0;
            mem_grant = !(t >= 13 && t <= 15);
            br        = (t == 20) || (t == 26) || (t == 34);
            br_addr   = (t == 20) ? 32'h3 : (t == 26) ? 32'h100 : 32'h8;
            track();
            @(negedge clk);

            if (t inside {0, 5, 11, 19, 23, 27, 35, 42, 47, 52}) begin
                chk("miss_stall_if", 32'(stall_if), 32'h1);
                chk("miss_no_req", 32'(mem_req), 32'h0);
            end
            do_addr = 1'b1;
            ea      = 32'h0;
            if (t >= 1 && t <= 4)        ea = 32'(t - 1);
            else if (t == 12)            ea = 32'h4;
            else if (t >= 13 && t <= 16) ea = 32'h5;
            else if (t == 17)            ea = 32'h6;
            else if (t == 18)            ea = 32'h7;
            else if (t >= 24 && t <= 26) ea = 32'(8 + t - 24);
            else if (t >= 28 && t <= 31) ea = 32'(32'h100 + t - 28);
            else if (t >= 36 && t <= 39) ea = 32'(8 + t - 36);
            else if (t >= 43 && t <= 45) ea = 32'(12 + t - 43);
            else if (t == 48)            ea = 32'h0;
            else                         do_addr = 1'b0;
            if (do_addr) begin
                chk("fetch_req", 32'(mem_req), 32'h1);
                chk("fetch_addr", mem_addr, ea);
            end
            if (t == 27) chk("redir_addr", mem_addr, 32'h100);
            if (t == 47) begin
                chk("post_rst_pc", pc, 32'h0);
                chk("post_rst_addr", mem_addr, 32'h0);
            end
            if ((t >= 6 && t <= 10) || t == 21 || t == 53) begin
                chk("ready_pc0", pc, 32'h0);
                chk("ready_inst0", inst, 32'h00100093);
                chk("ready_stall_if", 32'(stall_if), 32'h0);
                chk("ready_no_req", 32'(mem_req), 32'h0);
            end
            if (t == 20) begin
                chk("squash_inst_d", inst, 32'h0);
                chk("squash_pc", pc, 32'h4);
                chk("squash_stall_if", 32'(stall_if), 32'h0);
            end
            if (t == 22) begin
                chk("hit4_pc", pc, 32'h4);
                chk("hit4_inst", inst, word_at(32'h4));
            end
            if (t == 33) begin
                chk("w100_pc", pc, 32'h100);
                chk("w100_inst", inst, word_at(32'h100));
                chk("w100_stall_if", 32'(stall_if), 32'h0);
            end
            if (t == 41) begin
                chk("w8_pc", pc, 32'h8);
                chk("w8_inst", inst, word_at(32'h8));
                chk("w8_stall_if", 32'(stall_if), 32'h0);
            end
            if (t == 46) chk("rst_mid_fetch", 32'({mem_req, pc}), 33'h0);
            next_cycle();
        end

        // Randomized traffic: grant gaps, stalls, redirects (incl. wrap), rare resets.
        accepts = 0;
        for (int c = 0; c < 4000; c++) begin
            reset     = ($urandom_range(0, 499) == 0);
            stall     = 6'($urandom) & 6'($urandom);
            mem_grant = ($urandom_range(0, 3) != 0);
            br        = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) br_addr = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
            else if ($urandom_range(0, 3) == 0) br_addr = $urandom;
            else br_addr = 32'($urandom_range(0, 1023));
            track();
            next_cycle();
        end
        reset = 1'b0; br = 1'b0; stall = '0;
        chk("random_progress", 32'(accepts > 100), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
